// File: rtl/systolic_tile_seq_if.sv
// Sequencer-side bundle: start/k_len request, status pulses, tile-buffer read ports and array edge feeds.
// Pure wiring, no latency of its own.
// master = sequencer (drives reads, feeds, status); slave = buffer/array/host side.
interface systolic_tile_seq_if #(
    parameter int N          = 4,
    parameter int DATA_WIDTH = 16,
    parameter int K_MAX      = 64,
    parameter int KW         = $clog2(K_MAX + 1),
    parameter int AW         = $clog2(K_MAX)
);
    logic                    start;
    logic [KW-1:0]           k_len;
    logic                    busy;
    logic                    done;
    logic                    res_valid;
    logic                    pe_clr;
    logic                    a_rd_en;
    logic [AW-1:0]           a_rd_addr;
    logic [N*DATA_WIDTH-1:0] a_rd_data;
    logic                    b_rd_en;
    logic [AW-1:0]           b_rd_addr;
    logic [N*DATA_WIDTH-1:0] b_rd_data;
    logic [N*DATA_WIDTH-1:0] a_feed;
    logic [N*DATA_WIDTH-1:0] b_feed;

    modport master (
        input  start, k_len, a_rd_data, b_rd_data,
        output busy, done, res_valid, pe_clr,
               a_rd_en, a_rd_addr, b_rd_en, b_rd_addr, a_feed, b_feed
    );

    modport slave (
        output start, k_len, a_rd_data, b_rd_data,
        input  busy, done, res_valid, pe_clr,
               a_rd_en, a_rd_addr, b_rd_en, b_rd_addr, a_feed, b_feed
    );
endinterface

// File: rtl/systolic_tile_seq.sv
// Sequencer for an N x N output-stationary systolic tile: clear, stream K A-columns/B-rows with diagonal skew, drain, done.
// Latency: done/res_valid 1+k_eff+2N+1 cycles after an accepted start (2 cycles when k_eff=0).
// No backpressure: start is taken only in IDLE, ignored otherwise. Optional SEQ_PERF_CNT_EN adds perf counters.
module systolic_tile_seq #(
    parameter int N          = 4,
    parameter int DATA_WIDTH = 16,
    parameter int K_MAX      = 64,
    parameter int KW         = $clog2(K_MAX + 1),
    parameter int AW         = $clog2(K_MAX)
) (
    input  logic clk,
    input  logic rst_n,
    systolic_tile_seq_if.master bus
`ifdef SEQ_PERF_CNT_EN
    ,
    output logic [31:0] perf_tiles,
    output logic [31:0] perf_busy_cyc
`endif
);
    localparam int DCW = (2 * N > 1) ? $clog2(2 * N) : 1;

    typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_FEED, S_DRAIN, S_DONE} state_e;

    state_e          state_q, state_d;
    logic [KW-1:0]   k_eff_q, k_eff_d;
    logic [AW-1:0]   addr_q,  addr_d;
    logic [DCW-1:0]  drain_q, drain_d;
    logic            rd_en_q;

    // State and counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            k_eff_q <= '0;
            addr_q  <= '0;
            drain_q <= '0;
            rd_en_q <= 1'b0;
        end else begin
            state_q <= state_d;
            k_eff_q <= k_eff_d;
            addr_q  <= addr_d;
            drain_q <= drain_d;
            rd_en_q <= (state_q == S_FEED);
        end
    end

    // Next-state logic; the drain counter runs 2N-1..0 so DONE lands the cycle all psums are final
    always_comb begin
        state_d = state_q;
        k_eff_d = k_eff_q;
        addr_d  = addr_q;
        drain_d = drain_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d = S_CLEAR;
                    k_eff_d = (bus.k_len > KW'(K_MAX)) ? KW'(K_MAX) : bus.k_len;
                end
            end
            S_CLEAR: begin
                addr_d  = '0;
                drain_d = DCW'(2 * N - 1);
                state_d = (k_eff_q == '0) ? S_DONE : S_FEED;
            end
            S_FEED: begin
                if (KW'(addr_q) == k_eff_q - KW'(1)) begin
                    state_d = S_DRAIN;
                end else begin
                    addr_d = addr_q + 1'b1;
                end
            end
            S_DRAIN: begin
                if (drain_q == '0) begin
                    state_d = S_DONE;
                end else begin
                    drain_d = drain_q - 1'b1;
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.busy      = (state_q != S_IDLE);
    assign bus.done      = (state_q == S_DONE);
    assign bus.res_valid = (state_q == S_DONE);
    assign bus.pe_clr    = (state_q == S_CLEAR);
    assign bus.a_rd_en   = (state_q == S_FEED);
    assign bus.b_rd_en   = (state_q == S_FEED);
    assign bus.a_rd_addr = addr_q;
    assign bus.b_rd_addr = addr_q;

    // Lane i sees buffer data (gated by last cycle's read enable) through i extra register stages.
    // The buffer's own read register is lane 0's single stage.
    for (genvar i = 0; i < N; i++) begin : g_lane
        logic [DATA_WIDTH-1:0] a_in, b_in;
        assign a_in = rd_en_q ? bus.a_rd_data[i*DATA_WIDTH +: DATA_WIDTH] : '0;
        assign b_in = rd_en_q ? bus.b_rd_data[i*DATA_WIDTH +: DATA_WIDTH] : '0;
        if (i == 0) begin : g_direct
            assign bus.a_feed[0 +: DATA_WIDTH] = a_in;
            assign bus.b_feed[0 +: DATA_WIDTH] = b_in;
        end else begin : g_chain
            logic [DATA_WIDTH-1:0] a_sr_q [i];
            logic [DATA_WIDTH-1:0] b_sr_q [i];
            // Skew shift chain, flushed on the clear cycle
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int s = 0; s < i; s++) begin
                        a_sr_q[s] <= '0;
                        b_sr_q[s] <= '0;
                    end
                end else if (state_q == S_CLEAR) begin
                    for (int s = 0; s < i; s++) begin
                        a_sr_q[s] <= '0;
                        b_sr_q[s] <= '0;
                    end
                end else begin
                    a_sr_q[0] <= a_in;
                    b_sr_q[0] <= b_in;
                    for (int s = 1; s < i; s++) begin
                        a_sr_q[s] <= a_sr_q[s-1];
                        b_sr_q[s] <= b_sr_q[s-1];
                    end
                end
            end
            assign bus.a_feed[i*DATA_WIDTH +: DATA_WIDTH] = a_sr_q[i-1];
            assign bus.b_feed[i*DATA_WIDTH +: DATA_WIDTH] = b_sr_q[i-1];
        end
    end

`ifdef SEQ_PERF_CNT_EN
    logic [31:0] perf_tiles_q, perf_busy_cyc_q;

    // Saturating tile and busy-cycle counters, cleared only by reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_tiles_q    <= '0;
            perf_busy_cyc_q <= '0;
        end else begin
            if (state_q == S_DONE && perf_tiles_q != '1) begin
                perf_tiles_q <= perf_tiles_q + 32'd1;
            end
            if (state_q != S_IDLE && perf_busy_cyc_q != '1) begin
                perf_busy_cyc_q <= perf_busy_cyc_q + 32'd1;
            end
        end
    end

    assign perf_tiles    = perf_tiles_q;
    assign perf_busy_cyc = perf_busy_cyc_q;
`endif
endmodule

// File: tb/tb_systolic_tile_seq.sv
// Bench for systolic_tile_seq: tile-buffer and PE-array models around the sequencer,
// cycle-level expectations derived from tile start cycle and k_eff, psums vs matrix product.
module tb_systolic_tile_seq;
    localparam int N     = 4;
    localparam int DW    = 16;
    localparam int K_MAX = 64;
    localparam int KW    = $clog2(K_MAX + 1);
    localparam int AW    = $clog2(K_MAX);

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    systolic_tile_seq_if #(.N(N), .DATA_WIDTH(DW), .K_MAX(K_MAX)) bus ();

`ifdef SEQ_PERF_CNT_EN
    logic [31:0] perf_tiles, perf_busy_cyc;
`endif

    systolic_tile_seq #(.N(N), .DATA_WIDTH(DW), .K_MAX(K_MAX)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
`ifdef SEQ_PERF_CNT_EN
        ,
        .perf_tiles    (perf_tiles),
        .perf_busy_cyc (perf_busy_cyc)
`endif
    );

    int n_tests = 0;
    int n_fail  = 0;

    function automatic void chk(string nm, longint act, longint exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at t=%0t: got %0d, expected %0d", nm, $time, act, exp);
        end
    endfunction

    function automatic void fail_now(string nm);
        n_tests++;
        n_fail++;
        $display("FAIL %s at t=%0t: bound expired", nm, $time);
    endfunction

    // Tile buffers (1-cycle read latency)
    logic [DW-1:0] mem_a [K_MAX][N];
    logic [DW-1:0] mem_b [K_MAX][N];

    always @(posedge clk) begin
        if (bus.a_rd_en)
            for (int i = 0; i < N; i++) bus.a_rd_data[i*DW +: DW] <= mem_a[bus.a_rd_addr][i];
        if (bus.b_rd_en)
            for (int i = 0; i < N; i++) bus.b_rd_data[i*DW +: DW] <= mem_b[bus.b_rd_addr][i];
    end

    // Behavioural model: which tile is live, when it started, and its operands
    int            cyc     = 0;
    bit            t_valid = 1'b0;
    int            t_s     = 0;
    int            t_k     = 0;
    logic [DW-1:0] t_a [K_MAX][N];
    logic [DW-1:0] t_b [K_MAX][N];

    function automatic int tlen(int k);
        return (k == 0) ? 2 : k + 2 * N + 2;
    endfunction
    function automatic bit m_busy(int c);
        return t_valid && c >= t_s + 1 && c <= t_s + tlen(t_k);
    endfunction
    function automatic bit m_done(int c);
        return t_valid && c == t_s + tlen(t_k);
    endfunction
    function automatic bit m_clr(int c);
        return t_valid && c == t_s + 1;
    endfunction
    function automatic bit m_rd(int c);
        return t_valid && c >= t_s + 2 && c <= t_s + 1 + t_k;
    endfunction
    function automatic logic [DW-1:0] m_afeed(int c, int i);
        int e = c - t_s - 3 - i;
        if (t_valid && e >= 0 && e < t_k) return t_a[e][i];
        return '0;
    endfunction
    function automatic logic [DW-1:0] m_bfeed(int c, int j);
        int e = c - t_s - 3 - j;
        if (t_valid && e >= 0 && e < t_k) return t_b[e][j];
        return '0;
    endfunction

    // Model acceptance: a start is taken only when nothing is in flight
    always @(posedge clk) begin
        if (!rst_n) begin
            t_valid = 1'b0;
        end else if (bus.start && !m_busy(cyc)) begin
            t_valid = 1'b1;
            t_s     = cyc;
            t_k     = (int'(bus.k_len) > K_MAX) ? K_MAX : int'(bus.k_len);
            for (int k = 0; k < K_MAX; k++)
                for (int i = 0; i < N; i++) begin
                    t_a[k][i] = mem_a[k][i];
                    t_b[k][i] = mem_b[k][i];
                end
        end
        cyc = cyc + 1;
    end

    // PE array model fed from the DUT edges, plus per-cycle output comparison
    longint psum      [N][N];
    longint last_psum [N][N];
    longint ap [N][N];
    longint bp [N][N];
    int     done_cnt = 0;
    int     rd_cnt   = 0;

    always @(negedge clk) begin
        longint na [N][N];
        longint nb [N][N];
        longint r;
        if (!rst_n) begin
            for (int i = 0; i < N; i++)
                for (int j = 0; j < N; j++) begin
                    psum[i][j] = 0; ap[i][j] = 0; bp[i][j] = 0;
                end
        end else begin
            chk("busy",      longint'(bus.busy),      longint'(m_busy(cyc)));
            chk("done",      longint'(bus.done),      longint'(m_done(cyc)));
            chk("res_valid", longint'(bus.res_valid), longint'(m_done(cyc)));
            chk("pe_clr",    longint'(bus.pe_clr),    longint'(m_clr(cyc)));
            chk("a_rd_en",   longint'(bus.a_rd_en),   longint'(m_rd(cyc)));
            chk("b_rd_en",   longint'(bus.b_rd_en),   longint'(m_rd(cyc)));
            if (m_rd(cyc)) begin
                chk("a_rd_addr", longint'(bus.a_rd_addr), longint'(cyc - t_s - 2));
                chk("b_rd_addr", longint'(bus.b_rd_addr), longint'(cyc - t_s - 2));
            end
            for (int i = 0; i < N; i++) begin
                chk("a_feed", longint'(bus.a_feed[i*DW +: DW]), longint'(m_afeed(cyc, i)));
                chk("b_feed", longint'(bus.b_feed[i*DW +: DW]), longint'(m_bfeed(cyc, i)));
            end
            if (bus.a_rd_en) rd_cnt++;
            if (bus.done) begin
                done_cnt++;
                for (int i = 0; i < N; i++)
                    for (int j = 0; j < N; j++) begin
                        r = 0;
                        for (int k = 0; k < t_k; k++)
                            r += longint'($signed(t_a[k][i])) * longint'($signed(t_b[k][j]));
                        chk("psum", psum[i][j], r);
                        last_psum[i][j] = psum[i][j];
                    end
            end
            for (int i = 0; i < N; i++)
                for (int j = 0; j < N; j++) begin
                    na[i][j] = (j == 0) ? longint'($signed(bus.a_feed[i*DW +: DW])) : ap[i][j-1];
                    nb[i][j] = (i == 0) ? longint'($signed(bus.b_feed[j*DW +: DW])) : bp[i-1][j];
                end
            for (int i = 0; i < N; i++)
                for (int j = 0; j < N; j++) begin
                    if (bus.pe_clr) psum[i][j] = 0;
                    else            psum[i][j] += na[i][j] * nb[i][j];
                    ap[i][j] = na[i][j];
                    bp[i][j] = nb[i][j];
                end
        end
    end

    // Stimulus helpers (all called at a negedge)
    task automatic fill_rand();
        for (int k = 0; k < K_MAX; k++)
            for (int i = 0; i < N; i++) begin
                mem_a[k][i] = DW'($urandom());
                mem_b[k][i] = DW'($urandom());
            end
    endtask

    task automatic start_tile(input int k, output int s);
        bus.start = 1'b1;
        bus.k_len = KW'(k);
        s = cyc;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic wait_cyc(input int c);
        for (int n = 0; n < 500 && cyc < c; n++) @(negedge clk);
    endtask

    task automatic wait_done(input int budget, output int dc);
        dc = -1;
        for (int n = 0; n < budget; n++) begin
            if (bus.done) begin
                dc = cyc;
                return;
            end
            @(negedge clk);
        end
        fail_now("wait_done");
    endtask

    task automatic run_rand(input int kmax);
        int k, ke, s, dc;
        k  = $urandom_range(0, kmax);
        ke = (k > K_MAX) ? K_MAX : k;
        fill_rand();
        start_tile(k, s);
        wait_done(K_MAX + 3 * N + 10, dc);
        chk("rand_len", longint'(dc - s), longint'(tlen(ke)));
        repeat ($urandom_range(1, 3)) @(negedge clk);
    endtask

    initial begin
        int s, s2, dc, d0, r0;
        bus.start = 1'b0;
        bus.k_len = '0;
        for (int k = 0; k < K_MAX; k++)
            for (int i = 0; i < N; i++) begin
                mem_a[k][i] = '0;
                mem_b[k][i] = '0;
            end
        repeat (3) @(negedge clk);
        chk("rst_busy",   longint'(bus.busy),    0);
        chk("rst_done",   longint'(bus.done),    0);
        chk("rst_pe_clr", longint'(bus.pe_clr),  0);
        chk("rst_rd_en",  longint'(bus.a_rd_en), 0);
        chk("rst_a_feed", longint'(bus.a_feed),  0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Directed 4x3 * 3x4 tile
        for (int k = 0; k < 3; k++)
            for (int i = 0; i < N; i++) begin
                mem_a[k][i] = DW'(4 * k + i + 1);
                mem_b[k][i] = DW'(4 * k + i + 1);
            end
        start_tile(3, s);
        chk("d_pe_clr", longint'(bus.pe_clr), 1);
        wait_cyc(s + 2);
        chk("d_rd_addr0", longint'(bus.a_rd_addr), 0);
        wait_cyc(s + 3);
        chk("d_a0_first", longint'(bus.a_feed[0 +: DW]), 1);
        wait_cyc(s + 5);
        chk("d_a0_last", longint'(bus.a_feed[0 +: DW]), 9);
        wait_cyc(s + 6);
        chk("d_a3_first", longint'(bus.a_feed[3*DW +: DW]), 4);
        wait_cyc(s + 8);
        chk("d_a3_last", longint'(bus.a_feed[3*DW +: DW]), 12);
        wait_done(40, dc);
        chk("d_done_cyc", longint'(dc - s), 13);
        @(negedge clk);
        chk("d_busy_after", longint'(bus.busy), 0);
        chk("d_psum00", last_psum[0][0], 107);
        chk("d_psum33", last_psum[3][3], 224);
        chk("d_psum03", last_psum[0][3], 152);
        chk("d_psum21", last_psum[2][1], 158);
        @(negedge clk);

        // Empty tile
        start_tile(0, s);
        chk("k0_pe_clr", longint'(bus.pe_clr), 1);
        wait_done(10, dc);
        chk("k0_done_cyc", longint'(dc - s), 2);
        repeat (2) @(negedge clk);
        chk("k0_psum12", last_psum[1][2], 0);

        // Oversized k_len is clamped to K_MAX
        fill_rand();
        r0 = rd_cnt;
        start_tile(K_MAX + 5, s);
        wait_done(200, dc);
        chk("kmax_done_cyc", longint'(dc - s), longint'(1 + K_MAX + 2 * N + 1));
        chk("kmax_reads", longint'(rd_cnt - r0), longint'(K_MAX));
        repeat (2) @(negedge clk);

        // Starts during FEED and DONE are ignored
        fill_rand();
        d0 = done_cnt;
        start_tile(6, s);
        wait_cyc(s + 4);
        bus.start = 1'b1; bus.k_len = KW'(2);
        @(negedge clk);
        bus.start = 1'b0;
        wait_done(60, dc);
        chk("ign_done_cyc", longint'(dc - s), 16);
        bus.start = 1'b1; bus.k_len = KW'(1);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (20) @(negedge clk);
        chk("ign_done_cnt", longint'(done_cnt - d0), 1);
        chk("ign_idle", longint'(bus.busy), 0);
        run_rand(12);

        // Reset in the middle of DRAIN
        fill_rand();
        start_tile(5, s);
        wait_cyc(s + 9);
        #2 rst_n = 1'b0;
        #1;
        chk("mr_busy",   longint'(bus.busy),    0);
        chk("mr_done",   longint'(bus.done),    0);
        chk("mr_pe_clr", longint'(bus.pe_clr),  0);
        chk("mr_rd_en",  longint'(bus.a_rd_en) + longint'(bus.b_rd_en), 0);
        chk("mr_a_feed", longint'(bus.a_feed),  0);
        chk("mr_b_feed", longint'(bus.b_feed),  0);
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        run_rand(20);

        // Random tiles
        for (int t = 0; t < 6; t++) run_rand(K_MAX + 8);

        // Back-to-back tiles after a fresh reset
        #2 rst_n = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        fill_rand();
        start_tile(7, s);
        wait_done(60, dc);
        fill_rand();
        @(negedge clk);
        start_tile(4, s2);
        chk("b2b_start", longint'(s2 - dc), 1);
        wait_done(60, dc);
        chk("b2b_len2", longint'(dc - s2), 14);
        repeat (3) @(negedge clk);
`ifdef SEQ_PERF_CNT_EN
        chk("perf_tiles",    longint'(perf_tiles),    2);
        chk("perf_busy_cyc", longint'(perf_busy_cyc), 31);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end
endmodule

// File: doc/systolic_tile_seq.md
Name: systolic_tile_seq

Overview:
- Sequencer for an N x N output-stationary systolic array of multiply-accumulate PEs with optional ReLU.
- On `start`, pulses an array-wide accumulator clear and streams K columns of A and K rows of B from two tile buffers (1-cycle read latency) into the array edges with per-lane diagonal skew.
- Waits for the wavefront to drain, then pulses `done`/`res_valid` on the exact cycle all N*N psums are final.
- Sits between the tile-buffer/DMA layer and the PE array.

Parameters:
- N, 4, array dimension (rows = cols = N lanes).
- DATA_WIDTH, 16, signed operand width per lane.
- K_MAX, 64, maximum inner dimension per tile.
- KW, $clog2(K_MAX+1), width of k_len.
- AW, $clog2(K_MAX), tile-buffer address width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request to compute a tile; sampled only in IDLE.
- k_len  in  KW  inner dimension; sampled with start.
- busy  out  1  high from the cycle after an accepted start through the DONE cycle inclusive.
- done  out  1  one-cycle pulse, tile complete.
- res_valid  out  1  one-cycle pulse, coincident with done; array psums final.
- pe_clr  out  1  one-cycle synchronous accumulator clear to all PEs.
- a_rd_en  out  1  A buffer read enable.
- a_rd_addr  out  AW  A buffer address (k index).
- a_rd_data  in  N*DATA_WIDTH  A column k, lane i = row i; valid 1 cycle after a_rd_en.
- b_rd_en  out  1  B buffer read enable (always equal to a_rd_en).
- b_rd_addr  out  AW  B buffer address (always equal to a_rd_addr).
- b_rd_data  in  N*DATA_WIDTH  B row k, lane j = col j; valid 1 cycle after b_rd_en.
- a_feed  out  N*DATA_WIDTH  skewed A into the array's left edge, lane i to row i.
- b_feed  out  N*DATA_WIDTH  skewed B into the array's top edge, lane j to col j.

Behaviour:
- Reset (asynchronous): state IDLE; all counters, skew registers and outputs 0.
- FSM states: IDLE, CLEAR, FEED, DRAIN, DONE.
- IDLE -> CLEAR on start. Latch `k_eff = min(k_len, K_MAX)`. start outside IDLE is ignored, with no queuing.
- CLEAR (1 cycle):
  - pe_clr=1.
  - All skew registers zeroed.
  - Next state FEED if k_eff>0, else DONE (results are all zero).
- FEED (k_eff cycles):
  - rd_en=1 with addr = 0,1,...,k_eff-1.
  - Exit to DRAIN after addr k_eff-1 is issued.
- DRAIN: exactly 2N cycles, counted by a down-counter, then DONE.
- DONE (1 cycle): done=1, res_valid=1, then IDLE. A start in this cycle is ignored.
- Skew: the element read at cycle t appears on lane i of a_feed (and lane j of b_feed) at cycle t+1+i (resp. t+1+j). Lane 0 has one register stage; lane i has i+1 stages.
- Whenever rd_en was 0 in the previous cycle, zero enters the skew chains. Edge lanes therefore carry 0 outside valid data and never re-feed stale data.
- Timing check: with the last read at T, the last lane N-1 element reaches the edge at T+N and PE(N-1,N-1) at T+2N. Its accumulation completes at the T+2N+1 edge, which is the DONE cycle.
- Total busy cycles = 1 + k_eff + 2N + 1; for k_eff=0 this is 2.
- Arithmetic: no operand modification; the sequencer only moves words. Lane slice i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- Reset mid-operation returns to IDLE immediately with zeroed skew chains. No done is produced; the array is reset by the same rst_n.

Optional Feature:
- Macro: SEQ_PERF_CNT_EN.
- Defined: adds output ports `perf_tiles` (32 bits), incremented on each DONE, and `perf_busy_cyc` (32 bits), incremented each busy cycle. Both saturate at all-ones and are cleared only by rst_n.
- Undefined: the ports and counters do not exist; the behaviour above is unchanged.

Test Plan:
- N=4, k_len=3, A cols [1,2,3,4],[5,6,7,8],[9,10,11,12], B rows identical, start at cycle 0:
  - pe_clr at cycle 1.
  - rd_en cycles 2–4, addr 0,1,2.
  - a_feed lane 0 = 1,5,9 at cycles 3–5; lane 3 = 4,8,12 at cycles 6–8.
  - done/res_valid at cycle 13, busy low at cycle 14.
  - Reference PE array psum(i,j) = Σ_k A[i][k]·B[k][j].
- k_len=0 -> pe_clr at cycle 1, done at cycle 2, no rd_en, feeds stay 0.
- k_len=K_MAX+5 -> exactly K_MAX reads, addr wraps never, done at 1+K_MAX+2N+1 cycles after start.
- start pulsed during FEED and during DONE -> ignored; exactly one done; the next start from IDLE is accepted normally.
- rst_n asserted mid-DRAIN -> busy, done, pe_clr, rd_en, a_feed and b_feed all 0 asynchronously; a new tile after release completes with correct psums.
- Two back-to-back tiles with different data (second start the cycle after done) -> the second result excludes any first-tile contribution; with SEQ_PERF_CNT_EN, perf_tiles=2 and perf_busy_cyc equals the sum of both tiles' busy lengths.
